// File: rtl/rv32i_core.sv
// rv32i_core: single-cycle RV32I integer core fetching from a combinational instruction ROM
module rv32i_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] regs [0:31];
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (we && waddr != '0) regs[waddr] <= wdata;
  assign rdata1 = raddr1 == '0 ? '0 : regs[raddr1];
  assign rdata2 = raddr2 == '0 ? '0 : regs[raddr2];
endmodule

module rv32i_core #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  output logic [31:0] inst_addr_o
);
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR = 7'h63, OP_IMM = 7'h13, OP_REG = 7'h33;
  logic [31:0] pc, pc4, npc, wd, rs1_v, rs2_v, b, alu;
  logic [31:0] imm_i, imm_b, imm_u, imm_j;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [4:0]  sh;
  logic        we, alt, cond, take;
  assign op    = inst_i[6:0];
  assign f3    = inst_i[14:12];
  assign alt   = inst_i[30];
  assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u = {inst_i[31:12], 12'b0};
  assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign pc4   = pc + 32'd4;
  assign inst_addr_o = pc;
  rv32i_regs u_regs (
    .clk(clk), .rst(rst), .we(we), .waddr(inst_i[11:7]), .wdata(wd),
    .raddr1(inst_i[19:15]), .raddr2(inst_i[24:20]), .rdata1(rs1_v), .rdata2(rs2_v)
  );
  assign b  = op == OP_REG ? rs2_v : imm_i;
  assign sh = b[4:0];
  always_comb begin
    case (f3)
      3'd0:    alu = (op == OP_REG && alt) ? rs1_v - b : rs1_v + b;
      3'd1:    alu = rs1_v << sh;
      3'd2:    alu = {31'b0, $signed(rs1_v) < $signed(b)};
      3'd3:    alu = {31'b0, rs1_v < b};
      3'd4:    alu = rs1_v ^ b;
      3'd5:    alu = alt ? $unsigned($signed(rs1_v) >>> sh) : rs1_v >> sh;
      3'd6:    alu = rs1_v | b;
      default: alu = rs1_v & b;
    endcase
  end
  // funct3 010/011 are not branches; f3[0] inverts the base compare
  assign cond = f3[2] ? (f3[1] ? rs1_v < rs2_v : $signed(rs1_v) < $signed(rs2_v)) : rs1_v == rs2_v;
  assign take = (f3[2] | ~f3[1]) & (cond ^ f3[0]);
  always_comb begin
    we  = 1'b0;
    wd  = pc4;
    npc = pc4;
    case (op)
      OP_LUI:   begin we = 1'b1; wd = imm_u; end
      OP_AUIPC: begin we = 1'b1; wd = pc + imm_u; end
      OP_JAL:   begin we = 1'b1; npc = pc + imm_j; end
      OP_JALR:  begin we = 1'b1; npc = (rs1_v + imm_i) & ~32'd1; end
      OP_BR:    npc = take ? pc + imm_b : pc4;
      OP_IMM,
      OP_REG:   begin we = 1'b1; wd = alu; end
      default:  ;
    endcase
  end
  always_ff @(posedge clk) pc <= rst ? RESET_ADDR : npc;
endmodule

// File: tb/tb_rv32i_core.sv
// tb_rv32i_core: directed programs; expected PC/register values are queued per cycle and checked by a monitor
module tb_rv32i_core;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] inst, addr;
  logic [31:0] rom [0:4095];
  always #5 clk = ~clk;
  assign inst = rom[addr[13:2]];

  rv32i_core #(.RESET_ADDR(32'h0)) dut (.clk(clk), .rst(rst), .inst_i(inst), .inst_addr_o(addr));

  typedef struct {int cyc; int idx; logic [31:0] exp; string nm;} chk_t;
  chk_t        sb [$];
  chk_t        mc;
  logic [31:0] act;
  int          n_cmp = 0, n_bad = 0, cnt = 0;

  // cnt = instructions retired since the last reset edge
  always @(posedge clk) cnt <= rst ? 0 : cnt + 1;

  always @(negedge clk)
    if (!rst)
      while (sb.size() > 0 && sb[0].cyc <= cnt) begin
        mc  = sb.pop_front();
        act = mc.idx < 0 ? dut.inst_addr_o : dut.u_regs.regs[mc.idx];
        n_cmp++;
        if (act !== mc.exp) begin
          n_bad++;
          $display("FAIL %s @cycle %0d: got %h, expected %h", mc.nm, cnt, act, mc.exp);
        end
      end

  function automatic logic [31:0] ei(int imm, int rs1, int f3, int rd, int op = 'h13);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] er(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] eb(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] eu(int imm, int rd, int op);
    return {imm[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] ej(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction

  task automatic put(int cyc, int idx, logic [31:0] v, string nm);
    sb.push_back('{cyc, idx, v, nm});
  endtask
  task automatic ld(int a, logic [31:0] w);
    rom[a >> 2] = w;
  endtask
  task automatic arm();
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 4096; i++) rom[i] = 32'h0000_0013;
  endtask
  task automatic run(int hold);
    repeat (hold) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 300 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: %0d checks still pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    // ALU sequence
    arm();
    ld(0, 32'h0020_0513); ld(4, 32'h0015_8593); ld(8, 32'h00A5_8633); ld(12, 32'h40A6_06B3);
    ld(16, ei(-1, 0, 0, 1));       ld(20, er(0, 1, 0, 3, 2));    ld(24, er(0, 1, 0, 2, 3));
    ld(28, eu('h80000, 5, 'h37));  ld(32, ei('h404, 5, 5, 6));   ld(36, ei(4, 5, 5, 7));
    ld(40, ei('hF0, 1, 4, 8));     ld(44, ei('h7FF, 1, 7, 9));   ld(48, ei(-2048, 0, 6, 14));
    ld(52, ei(-1, 10, 3, 15));     ld(56, ei(0, 1, 2, 16));      ld(60, er(0, 10, 10, 1, 17));
    ld(64, er('h20, 10, 5, 5, 18)); ld(68, er(0, 11, 10, 6, 19)); ld(72, er(0, 10, 12, 7, 20));
    ld(76, ei(5, 0, 0, 0));        ld(80, er(0, 10, 5, 5, 21));  ld(84, er(0, 10, 1, 4, 22));
    ld(88, er('h20, 10, 0, 0, 23));
    for (int i = 0; i < 5; i++) put(i, -1, 32'(4 * i), "alu pc");
    put(4, 10, 32'd2, "addi x10"); put(4, 11, 32'd1, "addi x11");
    put(4, 12, 32'd3, "add x12");  put(4, 13, 32'd1, "sub x13");
    put(7, 1, 32'hFFFF_FFFF, "addi -1"); put(7, 2, 32'd1, "sltu"); put(7, 3, 32'd0, "slt");
    put(20, 5, 32'h8000_0000, "lui x5");   put(20, 6, 32'hF800_0000, "srai");
    put(20, 7, 32'h0800_0000, "srli");     put(20, 8, 32'hFFFF_FF0F, "xori");
    put(20, 9, 32'h0000_07FF, "andi");     put(20, 14, 32'hFFFF_F800, "ori sext");
    put(20, 15, 32'd1, "sltiu sext");      put(20, 16, 32'd1, "slti");
    put(20, 17, 32'd8, "sll");             put(20, 18, 32'hE000_0000, "sra");
    put(20, 19, 32'd3, "or");              put(20, 20, 32'd2, "and");
    put(20, 0, 32'd0, "x0 write ignored");
    put(23, 21, 32'h2000_0000, "srl");     put(23, 22, 32'hFFFF_FFFD, "xor");
    put(23, 23, 32'hFFFF_FFFE, "sub wrap"); put(23, -1, 32'd92, "alu end pc");
    run(2);
    // Reset clears state left by the ALU program
    arm();
    put(0, -1, 32'd0, "reset pc");
    for (int r = 0; r < 32; r++) put(0, r, 32'd0, $sformatf("reset x%0d", r));
    for (int i = 1; i < 4; i++) put(i, -1, 32'(4 * i), "nop pc");
    run(10);
    // Branches
    arm();
    ld(0, ei(-1, 0, 0, 1));  ld(4, ei(1, 0, 0, 2));  ld(8, eb(8, 1, 2, 6));  ld(12, ei(7, 0, 0, 4));
    ld(16, eb(8, 1, 2, 4));  ld(20, eb(8, 1, 2, 5)); ld(24, ei(8, 0, 0, 4)); ld(28, eb(8, 1, 2, 7));
    ld(32, eb(8, 2, 1, 1));  ld(36, ei(6, 0, 0, 4)); ld(40, ei(9, 0, 0, 5)); ld(44, 32'hFE00_0EE3);
    begin
      int tr [11] = '{0, 4, 8, 16, 20, 28, 32, 40, 44, 40, 44};
      for (int i = 0; i < 11; i++) put(i, -1, 32'(tr[i]), "branch pc");
    end
    put(10, 4, 32'd0, "skipped insts"); put(10, 5, 32'd9, "loop body");
    run(2);
    // Jumps and upper immediates
    arm();
    ld('h00, eu('h12345, 5, 'h37)); ld('h10, eu(1, 6, 'h17)); ld('h20, 32'h0100_00EF);
    ld('h30, ei('h41, 0, 0, 1));    ld('h34, ei(1, 1, 0, 5, 'h67));
    ld('h40, ei(3, 0, 0, 8));       ld('h44, ei('h10, 1, 0, 1, 'h67));
    put(1, 5, 32'h1234_5000, "lui");    put(5, 6, 32'h0000_1010, "auipc");
    put(8, -1, 32'h20, "pre-jal pc");   put(9, -1, 32'h30, "jal target"); put(9, 1, 32'h24, "jal link");
    put(10, 1, 32'h41, "addi x1");      put(11, -1, 32'h42, "jalr target"); put(11, 5, 32'h38, "jalr link");
    put(12, -1, 32'h46, "misaligned pc+4"); put(12, 8, 32'd3, "fetch at 0x42");
    put(13, -1, 32'h50, "jalr rd==rs1 target"); put(13, 1, 32'h4A, "jalr rd==rs1 link");
    run(2);
    // Compliance-style bltu self-test
    arm();
    ld(0, ei(1, 0, 0, 3));   ld(4, ei(-1, 0, 0, 1));   ld(8, ei(0, 0, 0, 2));   ld(12, eb(8, 1, 2, 6));
    ld(16, ej(32, 0));       ld(20, ei(2, 0, 0, 3));   ld(24, eb(24, 2, 1, 6)); ld(28, eb(8, 2, 1, 7));
    ld(32, ej(16, 0));       ld(36, ei(1, 0, 0, 27));  ld(40, ei(1, 0, 0, 26)); ld(44, ej(0, 0));
    ld(48, ei(1, 0, 0, 26)); ld(52, ej(0, 0));
    put(9, 26, 32'd1, "x26 test end"); put(9, 27, 32'd1, "x27 pass");
    put(9, 3, 32'd2, "x3 failing test number"); put(11, -1, 32'd44, "end loop pc");
    run(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rv32i_core.md
Name: rv32i_core

Overview:
- Single-issue RV32I integer core. Executes one instruction per clock cycle.
- Sits at SoC top level. Fetches 32-bit instructions from an external combinational instruction ROM through a PC-address/instruction-data port pair.
- Contains an internal 32x32 register file, instance u_regs, holding array regs[0:31], so benches can probe architectural registers by hierarchy.
- Has no data-memory port; loads and stores are out of scope.

Parameters:
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- inst_i  input  32  instruction word returned by the ROM for inst_addr_o, same cycle (combinational).
- inst_addr_o  output  32  byte address of the current instruction (= PC).

Behaviour:
- Reset: while rst=1 at a rising edge:
  - PC <= RESET_ADDR.
  - All regs[1..31] <= 0.
  - inst_addr_o = RESET_ADDR from the following cycle.
  - While rst is held, no instruction retires and there is no register write.
- Instruction ROM contract:
  - 4096 x 32-bit words, read combinationally.
  - Word index = inst_addr_o[13:2]; upper address bits ignored.
  - Contents preloaded by the bench.
- Execution: each cycle, decode inst_i, read rs1/rs2, compute the result and next PC. At the rising edge, write rd (if the instruction writes) and update PC.
- Latency: a register written by instruction N is visible to instruction N+1.
- Default next PC is PC+4. PC arithmetic is modulo 2^32.
- x0 reads as 0 always; writes to x0 are discarded.
- Register reads are asynchronous.
- Supported instructions:
  - LUI: rd = imm[31:12]<<12.
  - AUIPC: rd = PC + (imm<<12).
  - JAL: rd = PC+4; PC = PC + sext(J-imm).
  - JALR: rd = PC+4; PC = (rs1 + sext(I-imm)) & ~1. rs1 is read before rd is written, so rd==rs1 works.
  - BEQ, BNE, BLT, BGE: signed compares. If taken, PC = PC + sext(B-imm); otherwise PC+4.
  - BLTU, BGEU: unsigned compares, same target rule as above.
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
    - SLTIU compares unsigned against the sign-extended immediate.
    - Shift amount = imm[4:0]; funct7 bit 30 selects SRAI.
  - OP: ADD, SUB (funct7=0100000), SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
    - Shift amount = rs2[4:0].
  - Arithmetic is 32-bit wrap-around; overflow is ignored.
  - SLT/SLTU write 0 or 1.
- All other opcodes (loads, stores, FENCE, SYSTEM, illegal): treat as NOP. No register write; PC+4.
- Misaligned branch/jump targets are not trapped; PC takes the computed value.
- No exceptions, interrupts or CSRs.
- Pass/fail convention used by the compliance suite (programs write it; the core has no special hardware):
  - x26 = 1 marks test end.
  - x27 = 1 means pass.
  - x3 = failing test number.

Test Plan:
- Reset: hold rst=1 for 10 cycles, release → inst_addr_o=0 and all regs=0; next edges give inst_addr_o 4, 8, 12 with NOP (0x00000013) stream.
- ALU sequence:
  - Program: ADDI x10,x0,2; ADDI x11,x11,1; ADD x12,x11,x10; SUB x13,x12,x10.
  - Expected after 4 cycles: x10=2, x11=1, x12=3, x13=1.
  - Also: ADDI x1,x0,-1 then SLTU x2,x0,x1 → x2=1; SLT x3,x0,x1 → x3=0.
- Branches:
  - x1=0xFFFFFFFF, x2=1. BLTU x2,x1,+8 is taken (PC jumps by 8, skipped instruction has no effect).
  - BLT x2,x1,+8 is not taken (PC+4).
  - BEQ x0,x0,-4 loops back.
- Jumps:
  - JAL x1,+16 at PC 0x20 → x1=0x24, PC=0x30.
  - JALR x5,x1,1 with x1=0x41 → PC=0x42, x5=old PC+4.
- Upper immediates and x0:
  - LUI x5,0x12345 → 0x12345000.
  - AUIPC x6,1 at PC 0x10 → 0x1010.
  - ADDI x0,x0,5 leaves x0=0.
  - SRAI of 0x80000000 by 4 → 0xF8000000.
- Compliance: load rv32ui-p-bltu and similar ALU/branch images → x26 reaches 1, then x27=1 within 20 cycles; on fail, report x3.
